// File: rtl/delay_tester_pkg.sv
// Shared definitions for the delay-tester frame generator: FSM state
// encoding, EtherType constants and frame-size limits.
package delay_tester_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_MAC_DST,
    S_MAC_SRC,
    S_ETH_TYPE,
    S_SEQ,
    S_TS,
    S_PAYLOAD,
    S_GAP
  } state_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETHERTYPE_TEST = 16'h88B5;

  localparam int MIN_PAYLOAD = 46;
  localparam int MAX_PAYLOAD = 1500;
  localparam int MAX_JUMBO   = 9000;
  localparam int HDR_BYTES   = 14;

endpackage

// File: rtl/frame_field_mux.sv
// Combinational byte selector: maps (state, byte index) of the byte about
// to be driven onto the wire to its value. Byte 0 of the destination MAC
// is presented in WAIT_ACK, so MAC_DST index 0 carries byte 1.
module frame_field_mux
  import delay_tester_pkg::*;
#(
  parameter logic [47:0] MAC_SRC_ADDR = 48'h004e46324300,
  parameter logic [47:0] MAC_DST_ADDR = 48'h004e46324301,
  parameter logic [15:0] ETH_TYPE     = 16'h88B5,
  parameter int          SEQ_W        = 32,
  parameter int          IDX_W        = 16
) (
  input  state_t             state,
  input  logic [IDX_W-1:0]   idx,
  input  logic [SEQ_W-1:0]   seq,
  input  logic [31:0]        ts,
  output logic [7:0]         tx_byte
);

  localparam int SEQ_B = SEQ_W / 8;

  // Field select; all multi-byte fields go out most-significant byte first.
  always_comb begin
    tx_byte = 8'h00;
    case (state)
      S_WAIT_ACK: tx_byte = MAC_DST_ADDR[47:40];
      S_MAC_DST:  tx_byte = 8'(MAC_DST_ADDR >> (8 * (4 - int'(idx))));
      S_MAC_SRC:  tx_byte = 8'(MAC_SRC_ADDR >> (8 * (5 - int'(idx))));
      S_ETH_TYPE: tx_byte = 8'(ETH_TYPE >> (8 * (1 - int'(idx))));
      S_SEQ:      tx_byte = 8'(seq >> (8 * (SEQ_B - 1 - int'(idx))));
      S_TS:       tx_byte = 8'(ts >> (8 * (3 - int'(idx))));
      S_PAYLOAD:  tx_byte = idx[7:0];
      default:    tx_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/frame_sender_burst.sv
// Burst Ethernet test-frame generator driving the MAC byte-stream TX port.
// Frame: dst MAC, src MAC, EtherType, sequence number, pattern payload.
// Optional build macro FRAME_SENDER_TIMESTAMP_EN inserts a 4-byte
// big-endian tx_clk timestamp (captured on the ack cycle) after SEQ.
module frame_sender_burst
  import delay_tester_pkg::*;
#(
  parameter logic [47:0] MAC_SRC_ADDR = 48'h004e46324300,
  parameter logic [47:0] MAC_DST_ADDR = 48'h004e46324301,
  parameter logic [15:0] ETH_TYPE     = 16'h88B5,
  parameter int          LEN_W        = 14,
  parameter int          GAP_W        = 16,
  parameter int          SEQ_W        = 32
) (
  input  logic             tx_clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [15:0]      frame_count,
  input  logic [LEN_W-1:0] payload_len,
  input  logic [GAP_W-1:0] ifg_cycles,
  input  logic             jumbo_en,
  output logic             conf_tx_en,
  output logic             conf_tx_jumbo_en,
  output logic             conf_tx_no_gen_crc,
  output logic [7:0]       mac_tx_data,
  output logic             mac_tx_dvld,
  input  logic             mac_tx_ack,
  output logic             busy,
  output logic             frame_done,
  output logic [31:0]      frames_sent
);

  localparam int SEQ_B = SEQ_W / 8;
`ifdef FRAME_SENDER_TIMESTAMP_EN
  localparam int TS_B  = 4;
`else
  localparam int TS_B  = 0;
`endif
  localparam int CNT_W = (LEN_W > GAP_W) ? LEN_W : GAP_W;

  state_t             state, nxt_state;
  logic [CNT_W-1:0]   cnt, nxt_cnt;
  logic [15:0]        fc_q, burst_q;
  logic [GAP_W-1:0]   ifg_q;
  logic [LEN_W-1:0]   pay_last_q;
  logic [SEQ_W-1:0]   seq_q;
  logic [31:0]        ts_q;
  logic [CNT_W-1:0]   gap_last;
  logic               launch, nxt_last, nxt_dvld, burst_end;
  logic [7:0]         nxt_byte;

  // Saturate the requested length into [46, 1500] or [46, 9000].
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic jumbo);
    logic [LEN_W-1:0] hi;
    hi = jumbo ? LEN_W'(MAX_JUMBO) : LEN_W'(MAX_PAYLOAD);
    if (len < LEN_W'(MIN_PAYLOAD)) return LEN_W'(MIN_PAYLOAD);
    if (len > hi) return hi;
    return len;
  endfunction

  assign conf_tx_no_gen_crc = 1'b0;
  assign launch    = (state == S_IDLE) && start;
  assign gap_last  = (ifg_q == '0) ? '0 : CNT_W'(ifg_q) - CNT_W'(1);
  assign burst_end = stop || ((fc_q != 16'd0) && (burst_q == fc_q));

  // Next-state and byte-counter logic; the counter restarts on every state change.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + CNT_W'(1);
    case (state)
      S_IDLE: begin
        nxt_cnt = '0;
        if (start) nxt_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        nxt_cnt = '0;
        if (mac_tx_ack) nxt_state = S_MAC_DST;
      end
      S_MAC_DST:  if (cnt == CNT_W'(4)) begin nxt_state = S_MAC_SRC;  nxt_cnt = '0; end
      S_MAC_SRC:  if (cnt == CNT_W'(5)) begin nxt_state = S_ETH_TYPE; nxt_cnt = '0; end
      S_ETH_TYPE: if (cnt == CNT_W'(1)) begin nxt_state = S_SEQ;      nxt_cnt = '0; end
`ifdef FRAME_SENDER_TIMESTAMP_EN
      S_SEQ:      if (cnt == CNT_W'(SEQ_B - 1)) begin nxt_state = S_TS; nxt_cnt = '0; end
      S_TS:       if (cnt == CNT_W'(3)) begin nxt_state = S_PAYLOAD; nxt_cnt = '0; end
`else
      S_SEQ:      if (cnt == CNT_W'(SEQ_B - 1)) begin nxt_state = S_PAYLOAD; nxt_cnt = '0; end
`endif
      S_PAYLOAD:  if (cnt == CNT_W'(pay_last_q)) begin nxt_state = S_GAP; nxt_cnt = '0; end
      S_GAP: begin
        if (cnt == gap_last) begin
          nxt_cnt   = '0;
          nxt_state = burst_end ? S_IDLE : S_WAIT_ACK;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  assign nxt_last = (nxt_state == S_PAYLOAD) && (nxt_cnt == CNT_W'(pay_last_q));
  assign nxt_dvld = (nxt_state != S_IDLE) && (nxt_state != S_GAP);

  frame_field_mux #(
    .MAC_SRC_ADDR (MAC_SRC_ADDR),
    .MAC_DST_ADDR (MAC_DST_ADDR),
    .ETH_TYPE     (ETH_TYPE),
    .SEQ_W        (SEQ_W),
    .IDX_W        (CNT_W)
  ) u_mux (
    .state   (nxt_state),
    .idx     (nxt_cnt),
    .seq     (seq_q),
    .ts      (ts_q),
    .tx_byte (nxt_byte)
  );

  // Control state, counters and registered outputs.
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      seq_q            <= '0;
      burst_q          <= '0;
      frames_sent      <= '0;
      conf_tx_en       <= 1'b0;
      conf_tx_jumbo_en <= 1'b0;
      mac_tx_data      <= 8'h00;
      mac_tx_dvld      <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      state            <= nxt_state;
      cnt              <= nxt_cnt;
      conf_tx_en       <= 1'b1;
      conf_tx_jumbo_en <= jumbo_en;
      mac_tx_data      <= nxt_byte;
      mac_tx_dvld      <= nxt_dvld;
      busy             <= (nxt_state != S_IDLE);
      frame_done       <= nxt_last;
      if (launch) begin
        seq_q   <= '0;
        burst_q <= '0;
      end else if (nxt_last) begin
        seq_q       <= seq_q + SEQ_W'(1);
        burst_q     <= burst_q + 16'd1;
        frames_sent <= frames_sent + 32'd1;
      end
    end
  end

  // Burst configuration snapshot taken when a burst is launched.
  always_ff @(posedge tx_clk) begin
    if (launch) begin
      fc_q       <= frame_count;
      ifg_q      <= ifg_cycles;
      pay_last_q <= clamp_len(payload_len, jumbo_en) - LEN_W'(SEQ_B + TS_B + 1);
    end
  end

`ifdef FRAME_SENDER_TIMESTAMP_EN
  logic [31:0] cyc_cnt;

  // Free-running cycle counter; its value is captured on the ack cycle.
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt <= '0;
      ts_q    <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if ((state == S_WAIT_ACK) && mac_tx_ack) ts_q <= cyc_cnt;
    end
  end
`else
  assign ts_q = '0;
`endif

endmodule

// File: doc/frame_sender_burst.md
Name: frame_sender_burst

Overview:
Parametrised next-generation Ethernet test-frame generator for the delay tester. It drives the MAC byte-stream TX interface (data/dvld/ack), emitting bursts of frames. Each frame carries dst MAC, src MAC, EtherType, a sequence number and a pattern payload. Payload length, frame count and inter-frame gap are programmable at runtime. It sits between the control logic and the MAC TX port. The MAC adds preamble and FCS.

Parameters:
MAC_SRC_ADDR, 48'h004e46324300, source MAC address
MAC_DST_ADDR, 48'h004e46324301, destination MAC address
ETH_TYPE, 16'h88B5, EtherType field
LEN_W, 14, payload-length width (holds up to 9000)
GAP_W, 16, inter-frame-gap counter width
SEQ_W, 32, sequence number width (multiple of 8)

Ports:
tx_clk  in  1  TX clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  pulse; begins a burst (IDLE only)
stop  in  1  level; finish the current frame, then go IDLE
frame_count  in  16  frames per burst; 0 = continuous
payload_len  in  LEN_W  payload bytes requested
ifg_cycles  in  GAP_W  idle cycles between frames
jumbo_en  in  1  allows payloads up to 9000
conf_tx_en  out  1  MAC TX enable
conf_tx_jumbo_en  out  1  MAC jumbo enable
conf_tx_no_gen_crc  out  1  constant 0 (MAC generates FCS)
mac_tx_data  out  8  TX byte
mac_tx_dvld  out  1  TX data valid
mac_tx_ack  in  1  MAC accepted first byte
busy  out  1  high when not IDLE
frame_done  out  1  one-cycle pulse on the last byte of each frame
frames_sent  out  32  frames completed since reset, wraps

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- conf_tx_en goes to 1 on the first edge after reset release.
- conf_tx_jumbo_en is jumbo_en registered.
- All outputs are registered.
- States: IDLE, WAIT_ACK, MAC_DST(6), MAC_SRC(6), ETH_TYPE(2), SEQ(SEQ_W/8), PAYLOAD, GAP.
- Byte counter resets on every state change.
- IDLE:
  - When start=1: latch frame_count, ifg_cycles, jumbo_en and the clamped payload_len; clear seq to 0.
  - Enter WAIT_ACK. dvld=1 and data = dst byte 0 on the next cycle.
  - start in any other state is ignored.
- WAIT_ACK: dvld and data are held stable until mac_tx_ack=1. Byte 0 is consumed on that cycle. mac_tx_ack in any other state is ignored.
- After ack, one byte per cycle with dvld continuously high. No stalls.
- Byte order on the wire:
  - MAC fields: MSB first.
  - EtherType: MSB first.
  - Sequence number: big-endian.
  - PAYLOAD byte i (counting from the first byte after SEQ): i[7:0].
- Clamped length L:
  - Minimum 46.
  - Maximum 1500 when jumbo_en=0, 9000 when jumbo_en=1.
  - L includes the SEQ bytes, so PAYLOAD emits L - SEQ_W/8 bytes.
- Last byte: frame_done=1 and frames_sent+1, in the same cycle. seq+1 (wraps). dvld drops to 0 the next cycle.
- Frame length on the wire (excluding preamble/FCS) = 14 + L bytes.
- GAP: dvld=0 for max(ifg_cycles,1) cycles. Then:
  - go to IDLE if stop=1, or if frame_count≠0 and frames in this burst = frame_count;
  - otherwise go to WAIT_ACK.
- stop asserted mid-frame: the frame always completes, then the GAP runs, then IDLE.
- Async reset mid-frame: dvld and all outputs drop immediately; state returns to IDLE.
- frames_sent wraps 2^32-1 → 0.

Optional Feature:
FRAME_SENDER_TIMESTAMP_EN
- Defined: a free-running 32-bit tx_clk cycle counter runs from reset. Its value on the ack cycle is captured. A TS state (4 bytes, big-endian) is inserted between SEQ and PAYLOAD. The minimum L stays 46; PAYLOAD emits L - SEQ_W/8 - 4 bytes; pattern index i restarts at 0 after TS.
- Undefined: no counter, no TS state; the layout is exactly as in Behaviour.

Decomposition:
- Package delay_tester_pkg holds:
  - state encoding enum;
  - EtherType constants (IPv4 0x0800, ARP 0x0806, test 0x88B5);
  - MIN_PAYLOAD=46, MAX_PAYLOAD=1500, MAX_JUMBO=9000;
  - HDR_BYTES=14.
- One sub-module, frame_field_mux: a combinational byte selector. Inputs are state and byte index; output is the TX byte (MAC/type/seq/ts/pattern). The FSM and counters stay in the top module.

Test Plan:
- start, frame_count=1, payload_len=46, ifg=12, ack 3 cycles after dvld rises → 60 bytes: 00 4e 46 32 43 01, 00 4e 46 32 43 00, 88 b5, 00 00 00 00, 00..29. Data is stable before ack. Then frame_done, frames_sent=1, busy=0.
- payload_len=10 → clamped to 46. payload_len=2000 with jumbo_en=0 → 1500. payload_len=2000 with jumbo_en=1 → 2000 bytes of payload.
- frame_count=3, ifg=5 → three frames, seq 0,1,2. Exactly 5 dvld-low cycles between frames. frames_sent=3.
- frame_count=0 with stop raised during frame 4's PAYLOAD → frame 4 completes, GAP runs, then IDLE. frames_sent=4.
- reset_n low mid-MAC_SRC → dvld=0 asynchronously. After release: IDLE, conf_tx_en=1 one edge later. A new start gives a correct frame with seq 0.
- With FRAME_SENDER_TIMESTAMP_EN: ack held off 100 cycles → TS bytes equal the counter on the ack cycle; PAYLOAD emits L-8 bytes.
